// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the serial sequence detectors:
// FSM state encodings and the bit-counter width helper.
package seq_pkg;

    localparam logic [1:0] SER_IDLE   = 2'd0;
    localparam logic [1:0] SER_SHIFT  = 2'd1;
    localparam logic [1:0] SER_PARITY = 2'd2;

    // Counter wide enough to hold 0..width inclusive.
    function automatic int unsigned ser_cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load and per-bit enable.
// Optional macro SER_PARITY_EN appends one even-parity bit after each word.
module piso_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy
);

    localparam int unsigned   CW       = ser_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             handshake;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign last_bit = (cnt_q == LAST_CNT);
    assign shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

`ifdef SER_PARITY_EN
    assign load_ready = (state_q == SER_IDLE) || ((state_q == SER_PARITY) && bit_en);
`else
    assign load_ready = (state_q == SER_IDLE) || ((state_q == SER_SHIFT) && last_bit && bit_en);
`endif

    assign handshake = load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
`ifdef SER_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            SER_IDLE: begin
                ser_valid_d = 1'b0;
                ser_out_d   = 1'b0;
            end
            SER_SHIFT: begin
                if (bit_en) begin
                    shift_d = shifted;
                    if (last_bit) begin
`ifdef SER_PARITY_EN
                        state_d   = SER_PARITY;
                        ser_out_d = parity_q;
`else
                        state_d     = SER_IDLE;
                        ser_valid_d = 1'b0;
                        ser_out_d   = 1'b0;
                        cnt_d       = '0;
`endif
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        ser_out_d = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
                    end
                end
            end
`ifdef SER_PARITY_EN
            SER_PARITY: begin
                if (bit_en) begin
                    state_d     = SER_IDLE;
                    ser_valid_d = 1'b0;
                    ser_out_d   = 1'b0;
                    cnt_d       = '0;
                end
            end
`endif
            default: begin
                state_d     = SER_IDLE;
                ser_valid_d = 1'b0;
                ser_out_d   = 1'b0;
                cnt_d       = '0;
            end
        endcase

        // A handshake only happens in IDLE or on the final slot, so it overrides.
        if (handshake) begin
            state_d     = SER_SHIFT;
            shift_d     = data_in;
            cnt_d       = '0;
            ser_valid_d = 1'b1;
            ser_out_d   = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
`ifdef SER_PARITY_EN
            parity_d    = ^data_in;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SER_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
`ifdef SER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = (state_q != SER_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus;
// a per-instance bit scoreboard is fed on every observed load handshake.
module tb_piso_serializer;

`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = 8 + PAR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load_valid = 1'b0;
    logic       bit_en = 1'b0;

    logic ready_m, out_m, valid_m, busy_m;
    logic ready_l, out_l, valid_l, busy_l;

    int tests_run = 0;
    int tests_failed = 0;

    logic q_m[$];
    logic q_l[$];

    typedef struct {
        logic [7:0] word;
        logic [7:0] en_pat;
        int         exp_cycles;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .bit_en     (bit_en),
        .ser_out    (out_m),
        .ser_valid  (valid_m),
        .busy       (busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .bit_en     (bit_en),
        .ser_out    (out_l),
        .ser_valid  (valid_l),
        .busy       (busy_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at negedge; scoreboard samples at negedge+2.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            q_m.delete();
            q_l.delete();
        end else begin
            if (valid_m && bit_en) begin
                if (q_m.size() == 0) check("msb_extra_bit", 32'd1, 32'd0);
                else check("msb_bit", {31'd0, out_m}, {31'd0, q_m.pop_front()});
            end
            if (valid_l && bit_en) begin
                if (q_l.size() == 0) check("lsb_extra_bit", 32'd1, 32'd0);
                else check("lsb_bit", {31'd0, out_l}, {31'd0, q_l.pop_front()});
            end
            if (load_valid && ready_m) begin
                for (int i = 0; i < 8; i++) begin
                    q_m.push_back(data_in[7-i]);
                    q_l.push_back(data_in[i]);
                end
                if (PAR == 1) begin
                    q_m.push_back(^data_in);
                    q_l.push_back(^data_in);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int  cnt;
        logic prev_m, prev_l, prev_en, prev_v;
        @(negedge clk);
        data_in    = v.word;
        load_valid = 1'b1;
        bit_en     = 1'b0;
        #1 check("ready_idle", {31'd0, ready_m}, 32'd1);
        cnt    = 0;
        prev_v = 1'b0;
        prev_en = 1'b1;
        prev_m = 1'b0;
        prev_l = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            bit_en     = v.en_pat[k % 8];
            #1;
            if (!valid_m) break;
            cnt++;
            if (prev_v && !prev_en) begin
                check("msb_hold", {31'd0, out_m}, {31'd0, prev_m});
                check("lsb_hold", {31'd0, out_l}, {31'd0, prev_l});
            end
            prev_v  = valid_m;
            prev_en = bit_en;
            prev_m  = out_m;
            prev_l  = out_l;
        end
        check("valid_cycles", cnt, v.exp_cycles);
        check("busy_done", {31'd0, busy_m}, 32'd0);
        check("ready_done", {31'd0, ready_m}, 32'd1);
        check("msb_q_empty", q_m.size(), 32'd0);
        check("lsb_q_empty", q_l.size(), 32'd0);
    endtask

    initial begin
        int cnt;
        bit taken;

        vecs[0] = '{8'hB4, 8'hFF, 8 + PAR};
        vecs[1] = '{8'h01, 8'hFF, 8 + PAR};
        vecs[2] = '{8'hA5, 8'h99, (PAR == 1) ? 17 : 16};
        vecs[3] = '{8'h0F, 8'h55, (PAR == 1) ? 17 : 15};
        vecs[4] = '{8'h07, 8'hFF, 8 + PAR};
        vecs[5] = '{8'h80, 8'hFF, 8 + PAR};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, valid_m}, 32'd0);
        check("rst_out", {31'd0, out_m}, 32'd0);
        check("rst_busy", {31'd0, busy_m}, 32'd0);
        check("rst_ready", {31'd0, ready_m}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: second word offered while the first is shifting
        @(negedge clk);
        data_in    = 8'hB4;
        load_valid = 1'b1;
        bit_en     = 1'b1;
        cnt   = 0;
        taken = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            data_in    = 8'h0F;
            load_valid = !taken;
            bit_en     = 1'b1;
            #1;
            if (!valid_m) break;
            cnt++;
            if (k <= NBITS - 1) check("b2b_ready", {31'd0, ready_m}, {31'd0, k == NBITS - 1});
            if (k == NBITS - 1) taken = 1'b1;
        end
        check("b2b_cycles", cnt, 2 * NBITS);
        check("b2b_q_empty", q_m.size(), 32'd0);

        // Reset mid-word after three bits of 8'hFF
        @(negedge clk);
        data_in    = 8'hFF;
        load_valid = 1'b1;
        bit_en     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        bit_en = 1'b0;
        #1;
        check("midrst_valid", {31'd0, valid_m}, 32'd0);
        check("midrst_busy", {31'd0, busy_m}, 32'd0);
        check("midrst_ready", {31'd0, ready_m}, 32'd1);
        run_vec(vecs[5]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
